draw_rect_fill: RTL and testbench

Parametrised rectangle rasteriser that writes one colour ID into the VGA frame-buffer RAM over an arbitrary pixel rectangle, one pixel per cycle. It takes a corner-pair command through a valid/ready handshake. It normalises and clips the corners, then walks the rectangle row by row with an incremental row base, so the address path needs no per-pixel multiply. It honours a RAM stall input. It sits between user drawing logic (sprite, text and superpixel layers) and the VGA RAM write port.

---
 rtl/draw_rect_fill.sv | 115 +++++++++++
 tb/tb_draw_rect_fill.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_rect_fill.sv
// draw_rect_fill: rasterises one colour ID over a clipped pixel rectangle, one frame-buffer write per cycle.
// Ports: clk/rst (sync, active-high); icmd_vld/ocmd_rdy command handshake with corners ix0,iy0,ix1,iy1,
// colour idata and imode; istall freezes drawing; obusy, odone status; oaddr/odata/owren RAM write port.
// Define DRAW_RECT_OUTLINE_EN to enable outline mode (imode=1).
module draw_rect_fill #(
  parameter int PIXEL_X_WIDTH = 10,
  parameter int PIXEL_Y_WIDTH = 9,
  parameter logic [PIXEL_X_WIDTH-1:0] PIXEL_X_MAX = 10'd639,
  parameter logic [PIXEL_Y_WIDTH-1:0] PIXEL_Y_MAX = 9'd479,
  parameter int FB_STRIDE = 640,
  parameter int VGA_ADDR_WIDTH = 19,
  parameter int COLOR_ID_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      icmd_vld,
  output logic                      ocmd_rdy,
  input  logic [PIXEL_X_WIDTH-1:0]  ix0,
  input  logic [PIXEL_Y_WIDTH-1:0]  iy0,
  input  logic [PIXEL_X_WIDTH-1:0]  ix1,
  input  logic [PIXEL_Y_WIDTH-1:0]  iy1,
  input  logic [COLOR_ID_WIDTH-1:0] idata,
  input  logic                      imode,
  input  logic                      istall,
  output logic                      obusy,
  output logic                      odone,
  output logic [VGA_ADDR_WIDTH-1:0] oaddr,
  output logic [COLOR_ID_WIDTH-1:0] odata,
  output logic                      owren
);
  typedef enum logic [1:0] {IDLE, SETUP, DRAW, DONE} state_t;
  localparam logic [VGA_ADDR_WIDTH-1:0] STRIDE = VGA_ADDR_WIDTH'(FB_STRIDE);
  state_t state, state_n;
  logic [PIXEL_X_WIDTH-1:0] ax0, ax1, x_lo, x_hi, xl_c, xr_c, xl, xr, x;
  logic [PIXEL_Y_WIDTH-1:0] ay0, ay1, y_lo, y_hi, yt_c, yb_c, yt, yb, y;
  logic [COLOR_ID_WIDTH-1:0] color;
  logic [VGA_ADDR_WIDTH-1:0] rowbase;
  logic step, row_end, last, skip;
`ifdef DRAW_RECT_OUTLINE_EN
  logic mode;
  // interior rows of an outline jump straight from the left edge to the right edge
  assign skip = mode && y != yt && y != yb && x == xl;
`else
  logic unused_mode;
  assign unused_mode = imode;
  assign skip = 1'b0;
`endif
  always_comb begin
    x_lo = ax0 < ax1 ? ax0 : ax1;
    x_hi = ax0 < ax1 ? ax1 : ax0;
    y_lo = ay0 < ay1 ? ay0 : ay1;
    y_hi = ay0 < ay1 ? ay1 : ay0;
    xl_c = x_lo > PIXEL_X_MAX ? PIXEL_X_MAX : x_lo;
    xr_c = x_hi > PIXEL_X_MAX ? PIXEL_X_MAX : x_hi;
    yt_c = y_lo > PIXEL_Y_MAX ? PIXEL_Y_MAX : y_lo;
    yb_c = y_hi > PIXEL_Y_MAX ? PIXEL_Y_MAX : y_hi;
    step = state == DRAW && !istall;
    row_end = x == xr;
    last = row_end && y == yb;
    state_n = state == IDLE  ? (icmd_vld ? SETUP : IDLE) :
              state == SETUP ? DRAW :
              state == DRAW  ? (step && last ? DONE : DRAW) : IDLE;
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      ocmd_rdy <= 1'b1;
      obusy <= 1'b0;
      odone <= 1'b0;
      oaddr <= '0;
      odata <= '0;
      owren <= 1'b0;
      {ax0, ax1, ay0, ay1, color} <= '0;
      {xl, xr, x, yt, yb, y, rowbase} <= '0;
`ifdef DRAW_RECT_OUTLINE_EN
      mode <= 1'b0;
`endif
    end else begin
      ocmd_rdy <= state_n == IDLE;
      obusy <= state_n == SETUP || state_n == DRAW;
      odone <= state == DONE;
      owren <= step;
      oaddr <= step ? rowbase + VGA_ADDR_WIDTH'(x) : '0;
      odata <= step ? color : '0;
      if (state == IDLE && icmd_vld) begin
        ax0 <= ix0;
        ax1 <= ix1;
        ay0 <= iy0;
        ay1 <= iy1;
        color <= idata;
`ifdef DRAW_RECT_OUTLINE_EN
        mode <= imode;
`endif
      end
      if (state == SETUP) begin
        xl <= xl_c;
        xr <= xr_c;
        yt <= yt_c;
        yb <= yb_c;
        x <= xl_c;
        y <= yt_c;
        rowbase <= VGA_ADDR_WIDTH'(yt_c) * STRIDE;
      end
      if (step && !last) begin
        if (row_end) begin
          x <= xl;
          y <= y + PIXEL_Y_WIDTH'(1);
          rowbase <= rowbase + STRIDE;
        end else x <= skip ? xr : x + PIXEL_X_WIDTH'(1);
      end
    end
  end
endmodule

// File: tb/tb_draw_rect_fill.sv
// tb_draw_rect_fill: directed checks of handshake, fill order, clipping, stall, reset and outline mode.
module tb_draw_rect_fill;
  logic clk = 0, rst = 1, icmd_vld = 0, imode = 0, istall = 0;
  logic [9:0] ix0 = 0, ix1 = 0;
  logic [8:0] iy0 = 0, iy1 = 0;
  logic [7:0] idata = 0;
  logic ocmd_rdy, obusy, odone, owren;
  logic [18:0] oaddr;
  logic [7:0] odata;
  int cyc = 0, n_cmp = 0, n_fail = 0;
  int qc[$];
  logic [18:0] qa[$];
  logic [7:0] qd[$];
  draw_rect_fill dut (
    .clk(clk), .rst(rst), .icmd_vld(icmd_vld), .ocmd_rdy(ocmd_rdy),
    .ix0(ix0), .iy0(iy0), .ix1(ix1), .iy1(iy1), .idata(idata), .imode(imode),
    .istall(istall), .obusy(obusy), .odone(odone), .oaddr(oaddr), .odata(odata), .owren(owren)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (owren) begin
    qa.push_back(oaddr);
    qd.push_back(odata);
    qc.push_back(cyc);
  end
  task automatic send(input logic [9:0] x0, input logic [8:0] y0, input logic [9:0] x1,
                      input logic [8:0] y1, input logic [7:0] d, input logic m, output int acc);
    qa.delete();
    qd.delete();
    qc.delete();
    @(negedge clk);
    {ix0, iy0, ix1, iy1, idata, imode} = {x0, y0, x1, y1, d, m};
    icmd_vld = 1;
    @(negedge clk);
    acc = cyc;
    icmd_vld = 0;
  endtask
  task automatic wait_done(output bit got, output int at);
    got = 0;
    at = -1;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (odone) begin
        got = 1;
        at = cyc;
      end
    end
  endtask
  task automatic test_reset;
    rst = 1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({ocmd_rdy, obusy, odone, owren} !== 4'b1000 || oaddr !== 0 || odata !== 0) begin
      n_fail++;
      $display("FAIL reset: rdy/busy/done/wren=%b addr=%0d data=%h, want 1000 0 00",
               {ocmd_rdy, obusy, odone, owren}, oaddr, odata);
    end
    rst = 0;
  endtask
  task automatic test_single;
    int acc, at;
    bit got;
    send(5, 7, 5, 7, 8'h3C, 0, acc);
    wait_done(got, at);
    n_cmp++;
    if (!got || qa.size() != 1) begin
      n_fail++;
      $display("FAIL single_count: done=%0d writes=%0d, want 1 1", got, qa.size());
    end else begin
      n_cmp += 4;
      if (qa[0] !== 4485 || qd[0] !== 8'h3C) begin
        n_fail++;
        $display("FAIL single_write: addr=%0d data=%h, want 4485 3c", qa[0], qd[0]);
      end
      if (qc[0] != acc + 2) begin
        n_fail++;
        $display("FAIL single_latency: %0d, want 2", qc[0] - acc);
      end
      if (at != qc[0] + 1) begin
        n_fail++;
        $display("FAIL single_done: done cycle %0d, want %0d", at, qc[0] + 1);
      end
      if (ocmd_rdy !== 1 || obusy !== 0) begin
        n_fail++;
        $display("FAIL single_idle: rdy=%b busy=%b, want 1 0", ocmd_rdy, obusy);
      end
    end
  endtask
  task automatic test_fill_swapped;
    int acc, at;
    bit got;
    int exp_a[6] = '{650, 651, 652, 1290, 1291, 1292};
    send(12, 2, 10, 1, 8'hA5, 0, acc);
    wait_done(got, at);
    n_cmp++;
    if (!got || qa.size() != 6) begin
      n_fail++;
      $display("FAIL fill_count: done=%0d writes=%0d, want 1 6", got, qa.size());
    end else
      for (int i = 0; i < 6; i++) begin
        n_cmp++;
        if (qa[i] !== 19'(exp_a[i]) || qd[i] !== 8'hA5 || qc[i] != acc + 2 + i) begin
          n_fail++;
          $display("FAIL fill_write%0d: addr=%0d data=%h cyc=+%0d, want %0d a5 +%0d",
                   i, qa[i], qd[i], qc[i] - acc, exp_a[i], 2 + i);
        end
      end
  endtask
  task automatic test_clip;
    int acc, at;
    bit got;
    send(638, 479, 1000, 511, 8'h11, 0, acc);
    wait_done(got, at);
    n_cmp++;
    if (!got || qa.size() != 2) begin
      n_fail++;
      $display("FAIL clip_count: done=%0d writes=%0d, want 1 2", got, qa.size());
    end else begin
      n_cmp++;
      if (qa[0] !== 307198 || qa[1] !== 307199) begin
        n_fail++;
        $display("FAIL clip_addr: %0d %0d, want 307198 307199", qa[0], qa[1]);
      end
    end
  endtask
  task automatic test_stall;
    int acc, at, n;
    bit got;
    int exp_c[4] = '{2, 3, 7, 8};
    send(0, 0, 3, 0, 8'h77, 0, acc);
    n = 0;
    for (int i = 0; i < 20 && n < 2; i++) begin
      if (owren) n++;
      if (n < 2) @(negedge clk);
    end
    istall = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (owren !== 0 || oaddr !== 0) begin
        n_fail++;
        $display("FAIL stall_idle%0d: wren=%b addr=%0d, want 0 0", i, owren, oaddr);
      end
    end
    istall = 0;
    wait_done(got, at);
    n_cmp++;
    if (!got || qa.size() != 4) begin
      n_fail++;
      $display("FAIL stall_count: done=%0d writes=%0d, want 1 4", got, qa.size());
    end else
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (qa[i] !== 19'(i) || qc[i] != acc + exp_c[i]) begin
          n_fail++;
          $display("FAIL stall_write%0d: addr=%0d cyc=+%0d, want %0d +%0d",
                   i, qa[i], qc[i] - acc, i, exp_c[i]);
        end
      end
  endtask
  task automatic test_busy_reset;
    int acc, n;
    send(0, 0, 9, 9, 8'h42, 0, acc);
    repeat (4) @(negedge clk);
    n_cmp++;
    if (ocmd_rdy !== 0 || obusy !== 1 || owren !== 1) begin
      n_fail++;
      $display("FAIL busy_state: rdy=%b busy=%b wren=%b, want 0 1 1", ocmd_rdy, obusy, owren);
    end
    {ix0, iy0, ix1, iy1} = {10'd100, 9'd100, 10'd100, 9'd100};
    icmd_vld = 1;
    @(negedge clk);
    icmd_vld = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    n_cmp++;
    if ({ocmd_rdy, obusy, odone, owren} !== 4'b1000 || oaddr !== 0) begin
      n_fail++;
      $display("FAIL mid_reset: rdy/busy/done/wren=%b addr=%0d, want 1000 0",
               {ocmd_rdy, obusy, odone, owren}, oaddr);
    end
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (odone || owren) n++;
    end
    n_cmp++;
    if (n != 0) begin
      n_fail++;
      $display("FAIL after_reset: %0d cycles with done/wren, want 0", n);
    end
  endtask
  task automatic test_outline;
    int acc, at;
    bit got;
`ifdef DRAW_RECT_OUTLINE_EN
    localparam int N = 10;
    int exp_a[N] = '{0, 1, 2, 3, 640, 643, 1280, 1281, 1282, 1283};
`else
    localparam int N = 12;
    int exp_a[N] = '{0, 1, 2, 3, 640, 641, 642, 643, 1280, 1281, 1282, 1283};
`endif
    send(0, 0, 3, 2, 8'h5A, 1, acc);
    wait_done(got, at);
    n_cmp++;
    if (!got || qa.size() != N) begin
      n_fail++;
      $display("FAIL outline_count: done=%0d writes=%0d, want 1 %0d", got, qa.size(), N);
    end else
      for (int i = 0; i < N; i++) begin
        n_cmp++;
        if (qa[i] !== 19'(exp_a[i])) begin
          n_fail++;
          $display("FAIL outline_write%0d: addr=%0d, want %0d", i, qa[i], exp_a[i]);
        end
      end
  endtask
  task automatic test_back_to_back;
    int acc, at;
    bit got;
    send(1, 0, 1, 1, 8'h01, 0, acc);
    wait_done(got, at);
    send(2, 0, 2, 0, 8'h02, 0, acc);
    wait_done(got, at);
    n_cmp++;
    if (!got || qa.size() != 1 || qa[0] !== 2 || qd[0] !== 8'h02) begin
      n_fail++;
      $display("FAIL back_to_back: done=%0d writes=%0d, want 1 write addr 2 data 02", got, qa.size());
    end
  endtask
  initial begin
    test_reset;
    test_single;
    test_fill_swapped;
    test_clip;
    test_stall;
    test_busy_reset;
    test_outline;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
